cic_decim_param: RTL and testbench

- Parametrised single-clock CIC decimation filter for the 1-bit delta-sigma modulator bitstream.
- Successor to the fixed order-3, divide-by-64 CIC and its separate divided clock: the decimation tick is generated internally as a clock enable.
- Adds a runtime-selectable ratio, output normalisation, a settling/valid indication and snapshot-coherent byte readout for the 8-bit output pins.

---
 rtl/cic_decim_param.sv | 116 +++++++++++
 tb/tb_cic_decim_param.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cic_decim_param.sv
// Single-clock CIC decimator for a 1-bit delta-sigma stream with a runtime ratio,
// full-scale normalisation, settling indication and coherent byte readout.
module cic_decim_param #(
    parameter int ORDER     = 3,
    parameter int LOG2_RMAX = 7,
    parameter int W         = ORDER * LOG2_RMAX + 1,
    parameter int OUT_W     = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic [1:0]       dec_sel,
    input  logic [1:0]       byte_sel,
    output logic [OUT_W-1:0] dout,
    output logic             out_valid,
    output logic             settled,
    output logic [7:0]       byte_out
);
    localparam int CW  = LOG2_RMAX;
    localparam int SCW = $clog2(ORDER + 2);
    localparam int SW  = (OUT_W > 24) ? OUT_W : 24;

    logic [1:0]              act_sel;
    logic [CW-1:0]           cnt;
    logic [CW-1:0]           cnt_max;
    logic [CW:0]             r_full;
    logic [ORDER-1:0][W-1:0] integ;
    logic [ORDER-1:0][W-1:0] integ_nxt;
    logic [ORDER-1:0][W-1:0] dly;
    logic [ORDER:0][W-1:0]   comb;
    logic [W-1:0]            norm;
    int                      shamt;
    logic [SCW-1:0]          settle_cnt;
    logic [OUT_W-1:0]        snapshot;
    logic [SW-1:0]           snap_x;
    logic [7:0]              byte_nxt;
    logic                    tick;
    logic                    ratio_chg;

    always_comb begin
        r_full  = (CW+1)'(1) << (LOG2_RMAX - 3 + int'(act_sel));
        cnt_max = CW'(r_full - 1'b1);
    end

    assign tick      = (cnt == cnt_max);
    assign ratio_chg = (dec_sel != act_sel);

    // Integrators chain combinationally so the tick-cycle bit reaches the combs
    // in the same cycle; wrap-around modulo 2^W cancels in the comb differences.
    always_comb begin
        integ_nxt    = integ;
        integ_nxt[0] = integ[0] + W'(din);
        for (int k = 1; k < ORDER; k++)
            integ_nxt[k] = integ[k] + integ_nxt[k-1];
        comb[0] = integ_nxt[ORDER-1];
        for (int k = 0; k < ORDER; k++)
            comb[k+1] = comb[k] - dly[k];
        shamt = ORDER * (3 - int'(act_sel));
        norm  = comb[ORDER] << shamt;
    end

    always_comb begin
        snap_x   = SW'(snapshot);
        byte_nxt = 8'h00;
        unique case (byte_sel)
            2'd0:    byte_nxt = snap_x[7:0];
            2'd1:    byte_nxt = snap_x[15:8];
            2'd2:    byte_nxt = snap_x[23:16];
            default: byte_nxt = {settled, act_sel, 5'b0};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            integ      <= '0;
            dly        <= '0;
            cnt        <= '0;
            act_sel    <= dec_sel;
            settle_cnt <= '0;
            settled    <= 1'b0;
            dout       <= '0;
            out_valid  <= 1'b0;
            snapshot   <= '0;
            byte_out   <= '0;
        end else begin
            out_valid <= 1'b0;
            byte_out  <= byte_nxt;
            if (out_valid)
                snapshot <= dout;
            if (tick && ratio_chg) begin
                // New ratio: drop this sample and restart the filter from empty.
                integ      <= '0;
                dly        <= '0;
                cnt        <= '0;
                settled    <= 1'b0;
                settle_cnt <= '0;
                act_sel    <= dec_sel;
            end else begin
                integ <= integ_nxt;
                if (tick) begin
                    cnt  <= '0;
                    dly  <= comb[ORDER-1:0];
                    dout <= OUT_W'(norm);
                    if (settle_cnt == SCW'(ORDER)) begin
                        out_valid <= 1'b1;
                        settled   <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_cic_decim_param.sv
// Directed bench for cic_decim_param: expected samples are queued as stimulus is
// driven and matched against out_valid; random data is checked with a direct FIR model.
module tb_cic_decim_param;
    localparam int ORDER = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din = 1'b0;
    logic [1:0]  dec_sel = 2'd0;
    logic [1:0]  byte_sel = 2'd0;
    logic [23:0] dout;
    logic        out_valid;
    logic        settled;
    logic [7:0]  byte_out;

    cic_decim_param #(.ORDER(3), .LOG2_RMAX(7), .OUT_W(24)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .dec_sel(dec_sel), .byte_sel(byte_sel),
        .dout(dout), .out_valid(out_valid), .settled(settled), .byte_out(byte_out)
    );

    always #5 clk = ~clk;

    typedef struct { logic [23:0] val; int cyc; } exp_t;
    exp_t q[$];
    exp_t mon_e;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, pass_cnt = 0, fail_cnt = 0;
    int r_tb, sh_tb, tick_no, n_idx, hlen;
    bit chk_bytes = 1'b0;
    logic [23:0] snap_m = '0;
    bit hist [0:16383];
    int h [0:381];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [23:0] s, input logic [1:0] bs);
        case (bs)
            2'd0:    return s[7:0];
            2'd1:    return s[15:8];
            2'd2:    return s[23:16];
            default: return 8'h00;
        endcase
    endfunction

    // Impulse response of ORDER cascaded length-R boxcars.
    task automatic build_h(input int R);
        int a [0:381];
        int b [0:381];
        hlen = ORDER * (R - 1) + 1;
        for (int i = 0; i < 382; i++) a[i] = (i < R) ? 1 : 0;
        for (int p = 1; p < ORDER; p++) begin
            for (int j = 0; j < 382; j++) begin
                b[j] = 0;
                for (int i = 0; i < R && i <= j; i++) b[j] += a[j-i];
            end
            a = b;
        end
        h = a;
    endtask

    function automatic logic [23:0] fir_exp(input int n);
        longint acc = 0;
        for (int j = 0; j < hlen && j <= n; j++)
            if (hist[n-j]) acc += longint'(h[j]);
        acc = (acc << sh_tb) & 64'h3FFFFF;
        return 24'(acc);
    endfunction

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            chk("spurious_valid", q.size() > 0, 1);
            if (q.size() > 0) begin
                mon_e = q.pop_front();
                chk("dout", dout, mon_e.val);
                chk("valid_cycle", cyc, mon_e.cyc);
                snap_m = mon_e.val;
            end
        end
    end

    task automatic step(input bit b, input bit push, input logic [23:0] expv);
        logic [7:0] eb;
        exp_t e;
        din = b;
        eb = byte_of(snap_m, byte_sel);
        @(posedge clk);
        #1;
        if (push) begin
            e.val = expv;
            e.cyc = cyc;
            q.push_back(e);
        end
        if (chk_bytes) chk("byte_out", byte_out, eb);
        n_idx++;
    endtask

    // pat: 0 zeros, 1 ones, 2 alternating, 3 random (model-checked)
    task automatic frames(input int nf, input int pat, input logic [23:0] cexp);
        for (int k = 0; k < nf; k++) begin
            for (int j = 0; j < r_tb; j++) begin
                bit b;
                bit last;
                case (pat)
                    0:       b = 1'b0;
                    1:       b = 1'b1;
                    2:       b = (n_idx % 2 == 0);
                    default: b = bit'($urandom_range(0, 1));
                endcase
                last = (j == r_tb - 1);
                if (chk_bytes) byte_sel = 2'(cyc % 3);
                if (last) tick_no++;
                hist[n_idx] = b;
                step(b, last && (tick_no >= ORDER + 1), (pat == 3) ? fir_exp(n_idx) : cexp);
            end
            chk("settled", settled, tick_no >= ORDER + 1);
        end
    endtask

    task automatic do_reset(input logic [1:0] sel);
        @(negedge clk);
        #1;
        chk("drained", q.size(), 0);
        chk_bytes = 1'b0;
        rst_n = 1'b0;
        dec_sel = sel;
        din = 1'b0;
        byte_sel = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", dout, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_settled", settled, 0);
        chk("rst_byte", byte_out, 0);
        rst_n = 1'b1;
        n_idx = 0;
        tick_no = 0;
        snap_m = '0;
        r_tb = 16 << sel;
        sh_tb = ORDER * (3 - int'(sel));
        build_h(r_tb);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // all ones at R=64
        do_reset(2'd2);
        frames(6, 1, 24'h200000);

        // all zeros at R=16, then status byte
        do_reset(2'd0);
        frames(6, 0, 24'h000000);
        byte_sel = 2'd3;
        step(1'b0, 1'b0, 24'h0);
        chk("byte_status", byte_out, 8'h80);

        // alternating input at every ratio
        for (int s = 0; s < 4; s++) begin
            do_reset(2'(s));
            frames(6, 2, 24'h100000);
        end

        // ratio change 64 -> 128 requested mid-frame
        do_reset(2'd2);
        frames(5, 1, 24'h200000);
        for (int j = 0; j < 64; j++) begin
            if (j == 10) dec_sel = 2'd3;
            step(1'b1, 1'b0, 24'h0);
        end
        chk("chg_settled", settled, 0);
        tick_no = 0;
        r_tb = 128;
        frames(5, 1, 24'h200000);
        byte_sel = 2'd3;
        step(1'b1, 1'b0, 24'h0);
        chk("byte_status3", byte_out, 8'hE0);

        // random data through integrator wrap-around, R=64
        do_reset(2'd2);
        frames(157, 3, 24'h0);

        // byte readout while the snapshot moves, then reset mid-frame
        do_reset(2'd0);
        chk_bytes = 1'b1;
        frames(10, 3, 24'h0);
        for (int j = 0; j < 7; j++) step(1'b1, 1'b0, 24'h0);
        do_reset(2'd0);
        frames(2, 1, 24'h0);

        @(negedge clk);
        #1;
        chk("final_drained", q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
